// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; pointers wrap modulo DEPTH (power of 2).
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push,
  input  logic                   pop,
  input  wb_req_t                din,
  output wb_req_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: ALU results win, multi-cycle results queue in a FIFO.
// Optional macro RF_WB_FWD_EN enables read-during-write forwarding compares.
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   alu_valid,
  input  logic [REG_AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  output logic                   alu_stall,
  input  logic                   mc_valid,
  output logic                   mc_ready,
  input  logic [REG_AW-1:0]      mc_rd,
  input  logic [XLEN-1:0]        mc_data,
  output logic [REG_AW-1:0]      rw,
  output logic [XLEN-1:0]        data,
  output logic                   we,
  output logic [$clog2(DEPTH):0] pend_cnt,
  input  logic [REG_AW-1:0]      ra,
  input  logic [REG_AW-1:0]      rb,
  output logic                   fwd_a_hit,
  output logic                   fwd_b_hit,
  output logic [XLEN-1:0]        fwd_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE     = 1;

  wb_req_t       head;
  wb_req_t       mc_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          alu_win;
  logic          blocked;
  logic [CW-1:0] starve_cnt;

  assign mc_ready  = !fifo_full;
  assign mc_req    = '{rd: mc_rd, data: mc_data};
  // r0 results complete the handshake but are dropped here.
  assign fifo_push = mc_valid && mc_ready && (mc_rd != REG_ZERO);
  assign alu_win   = !alu_stall && alu_valid && (alu_rd != REG_ZERO);
  assign fifo_pop  = !alu_win && !fifo_empty;
  assign blocked   = alu_win && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mc_req),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pend_cnt)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      we         <= 1'b0;
      rw         <= REG_ZERO;
      data       <= '0;
      alu_stall  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      we <= alu_win || !fifo_empty;
      if (alu_win) begin
        rw   <= alu_rd;
        data <= alu_data;
      end else if (!fifo_empty) begin
        rw   <= head.rd;
        data <= head.data;
      end
      // A stall always pops the head, so it self-clears after one cycle.
      alu_stall  <= blocked && (starve_cnt == STARVE_LAST);
      starve_cnt <= blocked ? starve_cnt + CNT_ONE : '0;
    end
  end

`ifdef RF_WB_FWD_EN
  assign fwd_a_hit = we && (rw == ra) && (ra != REG_ZERO);
  assign fwd_b_hit = we && (rw == rb) && (rb != REG_ZERO);
  assign fwd_data  = data;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{ra, rb};
  assign fwd_a_hit = 1'b0;
  assign fwd_b_hit = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed vector bench for rf_wb_ctrl: ALU path, FIFO path, fill, starvation, r0, forwarding, reset.
module tb_rf_wb_ctrl;
  import rf_pkg::*;

`ifdef RF_WB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        we;
    logic [4:0]  rw;
    logic [31:0] data;
    logic [2:0]  pend;
    logic        ready;
    logic        stall;
    logic        fa;
    logic        fb;
  } vec_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic [4:0]  rw;
  logic [31:0] data;
  logic        we;
  logic [2:0]  pend_cnt;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [31:0] fwd_data;

  int n_vec  = 0;
  int n_fail = 0;

  rf_wb_ctrl #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .mc_valid  (mc_valid),
    .mc_ready  (mc_ready),
    .mc_rd     (mc_rd),
    .mc_data   (mc_data),
    .rw        (rw),
    .data      (data),
    .we        (we),
    .pend_cnt  (pend_cnt),
    .ra        (ra),
    .rb        (rb),
    .fwd_a_hit (fwd_a_hit),
    .fwd_b_hit (fwd_b_hit),
    .fwd_data  (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic e_we, input logic [4:0] e_rw,
                           input logic [31:0] e_data, input logic [2:0] e_pend,
                           input logic e_ready, input logic e_stall);
    n_vec++;
    chk({tag, ".we"},    32'(we),        32'(e_we));
    chk({tag, ".rw"},    32'(rw),        32'(e_rw));
    chk({tag, ".data"},  data,           e_data);
    chk({tag, ".pend"},  32'(pend_cnt),  32'(e_pend));
    chk({tag, ".ready"}, 32'(mc_ready),  32'(e_ready));
    chk({tag, ".stall"}, 32'(alu_stall), 32'(e_stall));
    $display("%s: we=%0d rw=%0d data=0x%0h pend=%0d ready=%0d stall=%0d",
             tag, we, rw, data, pend_cnt, mc_ready, alu_stall);
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic [4:0] a, input logic [4:0] b,
                              input logic e_we, input logic [4:0] e_rw, input logic [31:0] e_data,
                              input logic [2:0] e_pend, input logic e_ready, input logic e_stall,
                              input logic e_fa, input logic e_fb);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.ra = a; v.rb = b; v.we = e_we; v.rw = e_rw; v.data = e_data;
    v.pend = e_pend; v.ready = e_ready; v.stall = e_stall; v.fa = e_fa; v.fb = e_fb;
    return v;
  endfunction

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    mc_valid  = 1'b0; mc_rd  = 5'd0; mc_data  = 32'h0;
    ra = 5'd0; rb = 5'd0;
  endtask

  vec_t vecs[23];

  initial begin
    //             av ard   ad        mv mrd   md     ra     rb     we rw     data     pd rdy st fa fb
    vecs[0]  = mk(1, 5'd8,  32'h1234, 0, 5'd0,  32'h0,  5'd0,  5'd0,  1, 5'd8,  32'h1234, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  5'd0,  5'd0,  0, 5'd8,  32'h1234, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 5'd0,  32'h0,    1, 5'd16, 32'hAA, 5'd0,  5'd0,  0, 5'd8,  32'h1234, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 5'd0,  32'h0,    1, 5'd17, 32'hBB, 5'd0,  5'd16, 1, 5'd16, 32'hAA,   1, 1, 0, 0, 1);
    vecs[4]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  5'd17, 5'd0,  1, 5'd17, 32'hBB,   0, 1, 0, 1, 0);
    vecs[5]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  5'd17, 5'd0,  0, 5'd17, 32'hBB,   0, 1, 0, 0, 0);
    vecs[6]  = mk(1, 5'd1,  32'h101,  1, 5'd20, 32'hC0, 5'd0,  5'd0,  1, 5'd1,  32'h101,  1, 1, 0, 0, 0);
    vecs[7]  = mk(1, 5'd2,  32'h102,  1, 5'd21, 32'hC1, 5'd0,  5'd0,  1, 5'd2,  32'h102,  2, 1, 0, 0, 0);
    vecs[8]  = mk(1, 5'd3,  32'h103,  1, 5'd22, 32'hC2, 5'd0,  5'd0,  1, 5'd3,  32'h103,  3, 1, 0, 0, 0);
    vecs[9]  = mk(1, 5'd4,  32'h104,  1, 5'd23, 32'hC3, 5'd0,  5'd0,  1, 5'd4,  32'h104,  4, 0, 0, 0, 0);
    vecs[10] = mk(1, 5'd5,  32'h105,  1, 5'd24, 32'hC4, 5'd0,  5'd0,  1, 5'd5,  32'h105,  4, 0, 0, 0, 0);
    vecs[11] = mk(1, 5'd6,  32'h106,  1, 5'd24, 32'hC4, 5'd0,  5'd0,  1, 5'd6,  32'h106,  4, 0, 0, 0, 0);
    vecs[12] = mk(1, 5'd7,  32'h107,  1, 5'd24, 32'hC4, 5'd0,  5'd0,  1, 5'd7,  32'h107,  4, 0, 0, 0, 0);
    vecs[13] = mk(1, 5'd9,  32'h109,  1, 5'd24, 32'hC4, 5'd0,  5'd0,  1, 5'd9,  32'h109,  4, 0, 0, 0, 0);
    vecs[14] = mk(1, 5'd10, 32'h10A,  1, 5'd24, 32'hC4, 5'd0,  5'd0,  1, 5'd10, 32'h10A,  4, 0, 1, 0, 0);
    vecs[15] = mk(1, 5'd11, 32'h10B,  1, 5'd24, 32'hC4, 5'd0,  5'd0,  1, 5'd20, 32'hC0,   3, 1, 0, 0, 0);
    vecs[16] = mk(1, 5'd11, 32'h10B,  1, 5'd24, 32'hC4, 5'd0,  5'd0,  1, 5'd11, 32'h10B,  4, 0, 0, 0, 0);
    vecs[17] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  5'd0,  5'd0,  1, 5'd21, 32'hC1,   3, 1, 0, 0, 0);
    vecs[18] = mk(1, 5'd0,  32'hDEAD, 0, 5'd0,  32'h0,  5'd0,  5'd0,  1, 5'd22, 32'hC2,   2, 1, 0, 0, 0);
    vecs[19] = mk(1, 5'd12, 32'h10C,  1, 5'd0,  32'hEE, 5'd0,  5'd0,  1, 5'd12, 32'h10C,  2, 1, 0, 0, 0);
    vecs[20] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  5'd0,  5'd0,  1, 5'd23, 32'hC3,   1, 1, 0, 0, 0);
    vecs[21] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  5'd24, 5'd24, 1, 5'd24, 32'hC4,   0, 1, 0, 1, 1);
    vecs[22] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  5'd24, 5'd0,  0, 5'd24, 32'hC4,   0, 1, 0, 0, 0);

    clrn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0);
    clrn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      mc_valid  = vecs[i].mv; mc_rd  = vecs[i].mrd; mc_data  = vecs[i].md;
      ra = vecs[i].ra; rb = vecs[i].rb;
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].we, vecs[i].rw, vecs[i].data,
                vecs[i].pend, vecs[i].ready, vecs[i].stall);
      chk($sformatf("vec%0d.fwd_a", i), 32'(fwd_a_hit), 32'(vecs[i].fa & FWD_ON));
      chk($sformatf("vec%0d.fwd_b", i), 32'(fwd_b_hit), 32'(vecs[i].fb & FWD_ON));
      chk($sformatf("vec%0d.fwd_data", i), fwd_data, FWD_ON ? vecs[i].data : 32'h0);
    end

    // Mid-traffic asynchronous reset discards the queued result immediately.
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h10D;
    mc_valid  = 1'b1; mc_rd  = 5'd25; mc_data  = 32'hD5;
    @(posedge clk);
    #1;
    chk_state("pre_rst", 1'b1, 5'd13, 32'h10D, 3'd1, 1'b1, 1'b0);
    drive_idle();
    #2;
    clrn = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_state("rst_hold", 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    chk_state("post_rst", 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0);

    // Fresh traffic after reset: push at edge N, write at edge N+1.
    mc_valid = 1'b1; mc_rd = 5'd18; mc_data = 32'h5A5A;
    @(posedge clk);
    #1;
    mc_valid = 1'b0;
    chk_state("push_n", 1'b0, 5'd0, 32'h0, 3'd1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_state("write_n1", 1'b1, 5'd18, 32'h5A5A, 3'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
- Write-back controller: the single writer of the 32x32 register file. Drives its write address, write data and write enable.
- Merges two result sources. The single-cycle ALU path has fixed priority and no backpressure. The multi-cycle path (load/mul/div) uses a valid/ready handshake and is buffered in a small FIFO.
- Outputs are registered and connect directly to the register file's write port, which writes on posedge clk when we=1 and rw!=0.

Parameters:
- DEPTH, 4, multi-cycle result FIFO entries (power of 2, >=2)
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO head may be blocked by ALU writes before alu_stall asserts (>=1)

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  registered; upstream must hold the ALU result while high
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  FIFO can accept (combinational, = !full)
- mc_rd  in  5  multi-cycle destination register
- mc_data  in  32  multi-cycle result
- rw  out  5  register-file write address
- data  out  32  register-file write data
- we  out  1  register-file write enable
- pend_cnt  out  $clog2(DEPTH)+1  FIFO occupancy
- ra  in  5  read address A (forwarding)
- rb  in  5  read address B (forwarding)
- fwd_a_hit  out  1  qa must be replaced by fwd_data
- fwd_b_hit  out  1  qb must be replaced by fwd_data
- fwd_data  out  32  value being written this cycle

Behaviour:
- Reset (clrn=0, async): we=0, rw=0, data=0, alu_stall=0, FIFO empty, pend_cnt=0, starve counter=0. Reset mid-operation discards all queued results.
- Handshake:
  - mc push when mc_valid && mc_ready.
  - mc_rd==0 results are accepted but not enqueued.
  - Full FIFO deasserts mc_ready even if a pop occurs the same cycle.
  - mc_valid/mc_rd/mc_data must stay stable until accepted.
- Output stage, each posedge, first matching rule wins:
  1. alu_stall=0 && alu_valid && alu_rd!=0: load ALU result; we=1.
  2. FIFO non-empty: pop head into rw/data; we=1.
  3. Otherwise we=0; rw/data hold their last value.
  - alu_valid with alu_rd==0 writes nothing and frees the slot for a FIFO drain.
- Latency:
  - ALU result: one cycle to we.
  - mc result into an empty FIFO with no ALU write: push at edge N, we at edge N+1.
  - Push and pop in the same cycle: pend_cnt unchanged.
- FIFO preserves order. ALU writes may overtake queued mc writes; the issue logic is responsible for WAW ordering between the two sources.
- Starvation:
  - Counter increments on each cycle where the FIFO is non-empty and rule 1 wins. It clears on any pop or when the FIFO is empty.
  - When counter == STARVE_MAX-1, alu_stall is set at the next edge.
  - While alu_stall=1: alu_valid is ignored, the head drains, then alu_stall clears at that same edge.
  - alu_stall lasts exactly one cycle per event.
- Pointers wrap modulo DEPTH. pend_cnt ranges 0..DEPTH.
- The forwarding outputs exist regardless of the macro below.

Optional Feature:
- Macro RF_WB_FWD_EN.
- Defined: fwd_a_hit = we && rw==ra && ra!=0; fwd_b_hit likewise with rb; fwd_data = data. This covers the read-during-write cycle before the register file updates.
- Undefined: fwd_a_hit=fwd_b_hit=0, fwd_data=0, and no comparators are synthesised.

Decomposition:
- Shared package rf_pkg holds:
  - REG_AW=5, XLEN=32, REG_ZERO=5'd0
  - typedef wb_req_t {rd, data}, used by the FIFO entry and the output stage
- One natural sub-module: wb_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count and async active-low reset.

Test Plan:
- ALU only: alu_valid=1, alu_rd=8, alu_data=0x1234 at edge 1 -> we=1, rw=8, data=0x1234 after edge 1; we=0 next cycle if idle.
- MC path: mc push rd=16 0xAA, then rd=17 0xBB, no ALU -> writes r16 then r17 on consecutive cycles; pend_cnt returns to 0.
- Fill: 4 pushes while ALU writes every cycle -> mc_ready=0 at pend_cnt=4; a 5th mc_valid is held, not lost.
- Starvation: FIFO non-empty with continuous ALU writes -> alu_stall=1 for exactly one cycle after 8 blocked cycles; head written that cycle; counter cleared.
- r0 handling: alu_rd=0 with FIFO head rd=18 -> head drains that cycle; mc_rd=0 accepted, pend_cnt unchanged, never written.
- Forwarding (RF_WB_FWD_EN defined): we=1, rw=17, ra=17, rb=0 -> fwd_a_hit=1, fwd_b_hit=0, fwd_data=data. Macro undefined -> both hits 0. Mid-traffic clrn pulse -> we=0 and pend_cnt=0 immediately.
